// File: rtl/wall_follower_fsm.sv
// Wall-following motion controller with registered outputs.
// Follows either the left or the right wall, tracks the accumulated heading,
// and parks in STUCK after too many consecutive rotate commands.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   SEARCH   | idle or looking for a wall; drives forward until one appears
//   FOLLOW   | wall present on the followed side; drives forward along it
//   ROT_AWAY | obstacle ahead; rotating away from the followed wall
//   TURN_IN  | wall lost; rotated one step toward the followed side
//   FWD_IN   | stepped forward after turning in; re-checking for the wall
//   STUCK    | rotate budget exhausted; motion halted until en drops
module wall_follower_fsm #(
  parameter int SIDE        = 0,
  parameter int STUCK_LIMIT = 4,
  parameter int HEADING_W   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 head,
  input  logic                 wall,
  output logic                 front,
  output logic                 rotate,
  output logic                 rot_dir,
  output logic [HEADING_W-1:0] heading,
  output logic                 stuck,
  output logic [2:0]           state
);

  localparam int CNT_W = $clog2(STUCK_LIMIT + 1);
  // Rotation direction (1 = clockwise) that turns away from the followed wall.
  localparam logic AWAY_DIR = (SIDE == 0) ? 1'b1 : 1'b0;

  typedef enum logic [2:0] {
    S_SEARCH   = 3'd0,
    S_FOLLOW   = 3'd1,
    S_ROT_AWAY = 3'd2,
    S_TURN_IN  = 3'd3,
    S_FWD_IN   = 3'd4,
    S_STUCK    = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic                 front_q, front_d;
  logic                 rotate_q, rotate_d;
  logic                 rot_dir_q, rot_dir_d;
  logic [HEADING_W-1:0] heading_q, heading_d;
  logic                 stuck_q, stuck_d;
  logic [CNT_W-1:0]     rot_cnt_q, rot_cnt_d;

  logic   want_fwd;
  logic   want_rot;
  logic   want_dir;
  state_t nxt_state;

  // Next-state and registered-command computation.
  always_comb begin
    state_d   = state_q;
    front_d   = 1'b0;
    rotate_d  = 1'b0;
    rot_dir_d = 1'b0;
    heading_d = heading_q;
    stuck_d   = 1'b0;
    rot_cnt_d = rot_cnt_q;
    want_fwd  = 1'b0;
    want_rot  = 1'b0;
    want_dir  = AWAY_DIR;
    nxt_state = S_SEARCH;

    if (!en) begin
      state_d   = S_SEARCH;
      rot_cnt_d = '0;
    end else if (state_q == S_STUCK) begin
      stuck_d = 1'b1;
    end else begin
      case (state_q)
        S_SEARCH: begin
          if (head) begin
            want_rot  = 1'b1;
            nxt_state = S_ROT_AWAY;
          end else begin
            want_fwd  = 1'b1;
            nxt_state = wall ? S_FOLLOW : S_SEARCH;
          end
        end
        S_FOLLOW: begin
          if (head) begin
            want_rot  = 1'b1;
            nxt_state = S_ROT_AWAY;
          end else if (wall) begin
            want_fwd  = 1'b1;
            nxt_state = S_FOLLOW;
          end else begin
            want_rot  = 1'b1;
            want_dir  = ~AWAY_DIR;
            nxt_state = S_TURN_IN;
          end
        end
        S_ROT_AWAY: begin
          if (head) begin
            want_rot  = 1'b1;
            nxt_state = S_ROT_AWAY;
          end else begin
            want_fwd  = 1'b1;
            nxt_state = S_FOLLOW;
          end
        end
        S_TURN_IN: begin
          if (head) begin
            want_rot  = 1'b1;
            nxt_state = S_ROT_AWAY;
          end else begin
            want_fwd  = 1'b1;
            nxt_state = S_FWD_IN;
          end
        end
        S_FWD_IN: begin
          if (head) begin
            want_rot  = 1'b1;
            nxt_state = S_ROT_AWAY;
          end else if (wall) begin
            want_fwd  = 1'b1;
            nxt_state = S_FOLLOW;
          end else begin
            want_rot  = 1'b1;
            want_dir  = ~AWAY_DIR;
            nxt_state = S_TURN_IN;
          end
        end
        default: nxt_state = S_SEARCH;
      endcase

      // A rotate request with the budget already spent halts the robot instead.
      if (want_rot && (rot_cnt_q == CNT_W'(STUCK_LIMIT))) begin
        state_d = S_STUCK;
        stuck_d = 1'b1;
      end else if (want_rot) begin
        rotate_d  = 1'b1;
        rot_dir_d = want_dir;
        heading_d = want_dir ? heading_q + HEADING_W'(1) : heading_q - HEADING_W'(1);
        rot_cnt_d = rot_cnt_q + CNT_W'(1);
        state_d   = nxt_state;
      end else begin
        front_d   = want_fwd;
        rot_cnt_d = '0;
        state_d   = nxt_state;
      end
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_SEARCH;
      front_q   <= 1'b0;
      rotate_q  <= 1'b0;
      rot_dir_q <= 1'b0;
      heading_q <= '0;
      stuck_q   <= 1'b0;
      rot_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      front_q   <= front_d;
      rotate_q  <= rotate_d;
      rot_dir_q <= rot_dir_d;
      heading_q <= heading_d;
      stuck_q   <= stuck_d;
      rot_cnt_q <= rot_cnt_d;
    end
  end

  assign front   = front_q;
  assign rotate  = rotate_q;
  assign rot_dir = rot_dir_q;
  assign heading = heading_q;
  assign stuck   = stuck_q;
  assign state   = state_q;

endmodule

// File: tb/tb_wall_follower_fsm.sv
// Scoreboard bench for wall_follower_fsm: a left-wall and a right-wall
// instance share stimulus; a behavioural model predicts each cycle's command.
module tb_wall_follower_fsm;

  localparam int LIMIT = 4;

  typedef struct packed {
    logic       front;
    logic       rotate;
    logic       rot_dir;
    logic [1:0] heading;
    logic       stuck;
    logic [2:0] state;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       head = 1'b0;
  logic       wall = 1'b0;

  logic       front0, rotate0, rot_dir0, stuck0;
  logic [1:0] heading0;
  logic [2:0] state0;
  logic       front1, rotate1, rot_dir1, stuck1;
  logic [1:0] heading1;
  logic [2:0] state1;

  int checks = 0;
  int errors = 0;

  exp_t q0[$];
  exp_t q1[$];

  // Model state: mode names follow the debug encoding, rotations counted per side.
  int m_mode[2];
  int m_rots[2];
  int m_head[2];

  wall_follower_fsm #(.SIDE(0), .STUCK_LIMIT(LIMIT), .HEADING_W(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .head(head), .wall(wall),
    .front(front0), .rotate(rotate0), .rot_dir(rot_dir0),
    .heading(heading0), .stuck(stuck0), .state(state0)
  );

  wall_follower_fsm #(.SIDE(1), .STUCK_LIMIT(LIMIT), .HEADING_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .head(head), .wall(wall),
    .front(front1), .rotate(rotate1), .rot_dir(rot_dir1),
    .heading(heading1), .stuck(stuck1), .state(state1)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int s = 0; s < 2; s++) begin
      m_mode[s] = 0;
      m_rots[s] = 0;
      m_head[s] = 0;
    end
  endfunction

  // act: 0 = forward, 1 = rotate away, 2 = rotate toward
  function automatic exp_t model_step(int s, bit e_n, bit h, bit w);
    exp_t e;
    int   act;
    int   nxt;
    bit   cw;
    e = '0;
    act = 0;
    nxt = 0;
    if (!e_n) begin
      m_mode[s] = 0;
      m_rots[s] = 0;
    end else if (m_mode[s] == 5) begin
      e.stuck = 1'b1;
    end else begin
      if (h) begin
        act = 1;
        nxt = 2;
      end else begin
        case (m_mode[s])
          0: begin act = 0; nxt = w ? 1 : 0; end
          1: begin act = w ? 0 : 2; nxt = w ? 1 : 3; end
          2: begin act = 0; nxt = 1; end
          3: begin act = 0; nxt = 4; end
          default: begin act = w ? 0 : 2; nxt = w ? 1 : 3; end
        endcase
      end
      if (act != 0 && m_rots[s] == LIMIT) begin
        m_mode[s] = 5;
        e.stuck = 1'b1;
      end else if (act == 0) begin
        e.front = 1'b1;
        m_rots[s] = 0;
        m_mode[s] = nxt;
      end else begin
        cw = ((act == 1) == (s == 0));
        e.rotate = 1'b1;
        e.rot_dir = cw;
        m_head[s] = (m_head[s] + (cw ? 1 : 3)) % 4;
        m_rots[s] = m_rots[s] + 1;
        m_mode[s] = nxt;
      end
    end
    e.heading = 2'(m_head[s]);
    e.state = 3'(m_mode[s]);
    return e;
  endfunction

  task automatic step(input bit e_n, input bit h, input bit w);
    @(negedge clk);
    en = e_n;
    head = h;
    wall = w;
    q0.push_back(model_step(0, e_n, h, w));
    q1.push_back(model_step(1, e_n, h, w));
  endtask

  task automatic check_now(input string name, input exp_t act, input exp_t req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got f=%b r=%b d=%b h=%0d s=%b st=%0d, want f=%b r=%b d=%b h=%0d s=%b st=%0d",
               name, act.front, act.rotate, act.rot_dir, act.heading, act.stuck, act.state,
               req.front, req.rotate, req.rot_dir, req.heading, req.stuck, req.state);
    end
  endtask

  // Reset asserted between edges; outputs must clear without waiting for a clock.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_now("reset_dut0", {front0, rotate0, rot_dir0, heading0, stuck0, state0}, '0);
    check_now("reset_dut1", {front1, rotate1, rot_dir1, heading1, stuck1, state1}, '0);
    model_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // Monitor: every edge yields one command per instance; compare against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        check_now("cmd_left", {front0, rotate0, rot_dir0, heading0, stuck0, state0}, e);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        check_now("cmd_right", {front1, rotate1, rot_dir1, heading1, stuck1, state1}, e);
      end
    end
  end

  initial begin
    model_reset();
    do_reset();

    // Basic follow sequence, then drive to heading 2 in FOLLOW and reset mid-run.
    step(1, 0, 0); step(1, 0, 1); step(1, 0, 1); step(1, 1, 1); step(1, 0, 0);
    step(1, 0, 0); step(1, 0, 0); step(1, 0, 1);
    step(1, 1, 1); step(1, 1, 1); step(1, 0, 1);
    do_reset();
    step(1, 0, 0);

    // Lost wall from heading 0: heading wraps on the toward rotation.
    do_reset();
    step(1, 0, 1); step(1, 0, 0); step(1, 0, 0); step(1, 0, 1);

    // Stuck after LIMIT rotations; only en=0 releases it.
    do_reset();
    for (int i = 0; i < 6; i++) step(1, 1, 0);
    step(1, 0, 0); step(1, 0, 1);
    step(0, 0, 0);
    step(1, 0, 0);

    // Enable drop mid-FOLLOW holds heading.
    do_reset();
    step(1, 0, 1); step(1, 1, 1); step(1, 0, 1);
    step(0, 0, 1); step(0, 1, 0);
    step(1, 0, 1);

    // Randomised run with occasional enable drops and resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      step($urandom_range(0, 19) != 0, $urandom_range(0, 9) < 4, $urandom_range(0, 1) == 1);
    end

    @(posedge clk);
    #3;
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL drain: left=%0d right=%0d pending, want 0", q0.size(), q1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
